// File: rtl/pipeline_control_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_control_pkg
// Shared definitions for the pipeline stall/flush sequencer:
//   - state_e      : sequencer states
//   - STG_*        : bit index of each pipeline register in stage_en/stage_flush
//   - DRAIN_CYCLES : cycles spent draining EX, MEM and WB before halting
// -----------------------------------------------------------------------------
package pipeline_control_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        MC_WAIT = 2'd2,
        DRAIN   = 2'd3
    } state_e;

    localparam int STG_PC    = 0;
    localparam int STG_IFID  = 1;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 3;
    localparam int STG_MEMWB = 4;

    localparam int DRAIN_CYCLES = 3;

endpackage

// File: rtl/pipeline_control_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear. Clear wins over increment;
// the count sticks at all ones once reached.
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset (count -> 0)
//   clr_i   : synchronous clear
//   inc_i   : increment request
//   count_o : current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_control.sv
// -----------------------------------------------------------------------------
// pipeline_control
// Central stall/flush sequencer for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB
// registers. Drives the enable and synchronous clear of every register and
// arbitrates branch flushes, load-use bubbles, multi-cycle EX ops and halt.
// Outputs are Mealy so a hazard is handled in the cycle it is reported.
// Ports:
//   clk          : clock, rising edge
//   reset        : asynchronous active-low reset
//   start        : leave IDLE and begin execution
//   branch_taken : taken branch resolved in EX
//   mc_start     : multi-cycle op present in EX
//   load_use     : ID instruction depends on a load in EX
//   halt_req     : halt decoded in ID
//   stage_en     : per-register enable
//   stage_flush  : per-register synchronous clear
//   running      : high in RUN, MC_WAIT and DRAIN
//   halted       : sticky, set when a drain completes
//   stall_count  : saturating count of fetch-frozen cycles
// -----------------------------------------------------------------------------
module pipeline_control
    import pipeline_control_pkg::*;
#(
    parameter int NSTAGES = 5,
    parameter int MC_LAT  = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               branch_taken,
    input  logic               mc_start,
    input  logic               load_use,
    input  logic               halt_req,
    output logic [NSTAGES-1:0] stage_en,
    output logic [NSTAGES-1:0] stage_flush,
    output logic               running,
    output logic               halted,
    output logic [CNT_W-1:0]   stall_count
);

    // The mc_start cycle itself is one frozen cycle, so the wait counter
    // starts at MC_LAT-2. With MC_LAT=1 there is nothing to wait for.
    localparam int MC_CNT_W = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
    localparam int MC_LOAD  = (MC_LAT > 1) ? (MC_LAT - 2) : 0;

    state_e              state_q, state_d;
    logic [MC_CNT_W-1:0] mc_cnt_q, mc_cnt_d;
    logic [1:0]          drain_cnt_q, drain_cnt_d;
    logic                halted_q, halted_d;
    logic [NSTAGES-1:0]  stage_en_s;
    logic [NSTAGES-1:0]  stage_flush_s;
    logic                running_s;
    logic                stall_clr_s;
    logic                stall_inc_s;

    // Next-state and Mealy output logic.
    always_comb begin
        state_d       = state_q;
        mc_cnt_d      = mc_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        halted_d      = halted_q;
        stage_en_s    = '1;
        stage_flush_s = '0;
        running_s     = 1'b1;
        stall_clr_s   = 1'b0;
        case (state_q)
            IDLE: begin
                stage_en_s    = '0;
                stage_flush_s = '1;
                running_s     = 1'b0;
                if (start) begin
                    state_d     = RUN;
                    halted_d    = 1'b0;
                    stall_clr_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (branch_taken) begin
                    // PC still loads (the target); squash the two younger slots.
                    stage_flush_s[STG_IFID] = 1'b1;
                    stage_flush_s[STG_IDEX] = 1'b1;
                end else if ((MC_LAT > 1) && mc_start) begin
                    stage_en_s[STG_PC]         = 1'b0;
                    stage_en_s[STG_IFID]       = 1'b0;
                    stage_en_s[STG_IDEX]       = 1'b0;
                    stage_flush_s[STG_EXMEM]   = 1'b1;
                    mc_cnt_d                   = MC_CNT_W'(MC_LOAD);
                    state_d                    = MC_WAIT;
                end else if (load_use) begin
                    stage_en_s[STG_PC]       = 1'b0;
                    stage_en_s[STG_IFID]     = 1'b0;
                    stage_flush_s[STG_IDEX]  = 1'b1;
                end else if (halt_req) begin
                    stage_en_s[STG_PC]       = 1'b0;
                    stage_en_s[STG_IFID]     = 1'b0;
                    stage_flush_s[STG_IDEX]  = 1'b1;
                    drain_cnt_d              = 2'(DRAIN_CYCLES - 1);
                    state_d                  = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            MC_WAIT: begin
                if (mc_cnt_q != '0) begin
                    stage_en_s[STG_PC]       = 1'b0;
                    stage_en_s[STG_IFID]     = 1'b0;
                    stage_en_s[STG_IDEX]     = 1'b0;
                    stage_flush_s[STG_EXMEM] = 1'b1;
                    mc_cnt_d                 = mc_cnt_q - MC_CNT_W'(1);
                end else begin
                    // Result is ready: EX/MEM captures it with RUN defaults.
                    state_d = RUN;
                end
            end
            DRAIN: begin
                stage_en_s[STG_PC]      = 1'b0;
                stage_en_s[STG_IFID]    = 1'b0;
                stage_flush_s[STG_IFID] = 1'b1;
                stage_flush_s[STG_IDEX] = 1'b1;
                if (drain_cnt_q != 2'd0) begin
                    drain_cnt_d = drain_cnt_q - 2'd1;
                end else begin
                    halted_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                stage_en_s    = '0;
                stage_flush_s = '1;
                running_s     = 1'b0;
                state_d       = IDLE;
            end
        endcase
    end

    // Fetch is frozen whenever the PC enable is low outside IDLE.
    assign stall_inc_s = (state_q != IDLE) && !stage_en_s[STG_PC];

    // Sequencer state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mc_cnt_q    <= '0;
            drain_cnt_q <= 2'd0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mc_cnt_q    <= mc_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            halted_q    <= halted_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clr_i   (stall_clr_s),
        .inc_i   (stall_inc_s),
        .count_o (stall_count)
    );

    assign stage_en    = stage_en_s;
    assign stage_flush = stage_flush_s;
    assign running     = running_s;
    assign halted      = halted_q;

endmodule

// File: tb/tb_pipeline_control.sv
// -----------------------------------------------------------------------------
// tb_pipeline_control
// Directed scoreboard bench: each stimulus cycle pushes its expected output
// record; a negedge monitor pops and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_pipeline_control;

    typedef struct packed {
        logic [4:0]  en;
        logic [4:0]  fl;
        logic        run;
        logic        hal;
        logic [15:0] cnt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        branch_taken;
    logic        mc_start;
    logic        load_use;
    logic        halt_req;
    logic [4:0]  stage_en;
    logic [4:0]  stage_flush;
    logic        running;
    logic        halted;
    logic [15:0] stall_count;

    exp_t  exp_q[$];
    string name_q[$];
    int    tests_run;
    int    tests_failed;
    exp_t  mon_exp;
    exp_t  mon_act;
    string mon_name;

    pipeline_control #(
        .NSTAGES (5),
        .MC_LAT  (4),
        .CNT_W   (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .branch_taken (branch_taken),
        .mc_start     (mc_start),
        .load_use     (load_use),
        .halt_req     (halt_req),
        .stage_en     (stage_en),
        .stage_flush  (stage_flush),
        .running      (running),
        .halted       (halted),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare DUT outputs against the oldest expected record.
    always @(negedge clk) begin
        if (branch_taken && mc_start) begin
            $error("FAIL illegal_combo: branch_taken and mc_start both high");
        end
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act  = {stage_en, stage_flush, running, halted, stall_count};
            tests_run++;
            if (mon_act !== mon_exp) begin
                tests_failed++;
                $display("FAIL %s: got en=%b fl=%b run=%b halt=%b cnt=%0d, expected en=%b fl=%b run=%b halt=%b cnt=%0d",
                         mon_name, mon_act.en, mon_act.fl, mon_act.run, mon_act.hal, mon_act.cnt,
                         mon_exp.en, mon_exp.fl, mon_exp.run, mon_exp.hal, mon_exp.cnt);
            end
        end
    end

    // One clock cycle of stimulus plus its expected outputs for that cycle.
    task automatic cyc(input logic st, input logic bt, input logic mc,
                       input logic lu, input logic hr,
                       input logic [4:0] en, input logic [4:0] fl,
                       input logic run, input logic hal,
                       input logic [15:0] cnt, input string nm);
        @(posedge clk);
        #1;
        start        = st;
        branch_taken = bt;
        mc_start     = mc;
        load_use     = lu;
        halt_req     = hr;
        exp_q.push_back(exp_t'{en, fl, run, hal, cnt});
        name_q.push_back(nm);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        start        = 1'b0;
        branch_taken = 1'b0;
        mc_start     = 1'b0;
        load_use     = 1'b0;
        halt_req     = 1'b0;
        #2;
        exp_q.push_back(exp_t'{5'b00000, 5'b11111, 1'b0, 1'b0, 16'd0});
        name_q.push_back("in_reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        //  st    bt    mc    lu    hr    en        flush     run   halt  cnt
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b11111, 1'b0, 1'b0, 16'd0, "idle_start");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 5'b00000, 1'b1, 1'b0, 16'd0, "run_default");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b11100, 5'b00100, 1'b1, 1'b0, 16'd0, "load_use");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 5'b00000, 1'b1, 1'b0, 16'd1, "after_lu");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11000, 5'b01000, 1'b1, 1'b0, 16'd1, "mc_start");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b11000, 5'b01000, 1'b1, 1'b0, 16'd2, "mc_wait1");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000, 5'b01000, 1'b1, 1'b0, 16'd3, "mc_wait2");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 5'b00000, 1'b1, 1'b0, 16'd4, "mc_done");
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b11111, 5'b00110, 1'b1, 1'b0, 16'd4, "branch_lu");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'b11111, 5'b00110, 1'b1, 1'b0, 16'd4, "branch_halt");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 5'b00000, 1'b1, 1'b0, 16'd4, "after_branch");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b11100, 5'b00100, 1'b1, 1'b0, 16'd4, "lu_over_halt");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 5'b00000, 1'b1, 1'b0, 16'd5, "still_run");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b11100, 5'b00100, 1'b1, 1'b0, 16'd5, "halt");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11100, 5'b00110, 1'b1, 1'b0, 16'd6, "drain1");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11100, 5'b00110, 1'b1, 1'b0, 16'd7, "drain2");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11100, 5'b00110, 1'b1, 1'b0, 16'd8, "drain3");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 5'b11111, 1'b0, 1'b1, 16'd9, "idle_halted");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b11111, 1'b0, 1'b1, 16'd9, "restart");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 5'b00000, 1'b1, 1'b0, 16'd0, "run_cleared");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11000, 5'b01000, 1'b1, 1'b0, 16'd0, "mc2_start");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000, 5'b01000, 1'b1, 1'b0, 16'd1, "mc2_wait1");

        // MC_WAIT with counter=1: assert reset mid-cycle, no clock edge
        // before the monitor samples.
        @(posedge clk);
        #1;
        start        = 1'b0;
        branch_taken = 1'b0;
        mc_start     = 1'b0;
        load_use     = 1'b0;
        halt_req     = 1'b0;
        #1 reset = 1'b0;
        exp_q.push_back(exp_t'{5'b00000, 5'b11111, 1'b0, 1'b0, 16'd0});
        name_q.push_back("async_reset");
        @(posedge clk);
        #1 reset = 1'b1;

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b11111, 1'b0, 1'b0, 16'd0, "idle_after_rst");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 5'b00000, 1'b1, 1'b0, 16'd0, "run_after_rst");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 5'b00000, 1'b1, 1'b0, 16'd0, "run_steady");

        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain_queue: got %0d pending records, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
- Central stall/flush sequencer for the 5-register processor pipeline: PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Each register is a resetable flip-flop with a synchronous `reset` (clear) and an `enable`. This block drives both of those inputs for every register.
- It arbitrates branch flushes, load-use bubbles, multi-cycle EX operations and program halt. It also keeps a saturating stall counter for profiling.

Parameters:
- NSTAGES, 5, number of pipeline registers controlled; index 0=PC, 1=IF/ID, 2=ID/EX, 3=EX/MEM, 4=MEM/WB.
- MC_LAT, 4, total EX cycles of a multi-cycle operation; must be ≥1.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  leave IDLE and begin execution.
- branch_taken  in  1  taken branch resolved in EX this cycle.
- mc_start  in  1  multi-cycle operation present in EX this cycle.
- load_use  in  1  ID instruction depends on a load in EX.
- halt_req  in  1  halt instruction decoded in ID.
- stage_en  out  NSTAGES  enable to each pipeline register.
- stage_flush  out  NSTAGES  synchronous clear to each pipeline register.
- running  out  1  high in RUN, MC_WAIT and DRAIN.
- halted  out  1  sticky; set when a drain completes.
- stall_count  out  CNT_W  saturating count of fetch-frozen cycles.

Behaviour:
- States: IDLE, RUN, MC_WAIT, DRAIN.
- Outputs are Mealy: a combinational function of state and inputs, so hazards are handled in the same cycle.
- Reset (reset=0, asynchronous, any state) gives:
  - state=IDLE, mc counter=0, drain counter=0, halted=0, stall_count=0.
  - Outputs take their IDLE values.
- IDLE: stage_en=0, stage_flush=all ones, running=0.
  - start=1 → RUN next cycle.
  - The same edge clears stall_count and halted.
  - All other inputs are ignored.
- RUN default: stage_en=all ones, stage_flush=0. Priority, highest first:
  1. branch_taken:
     - stage_flush[1]=stage_flush[2]=1; stage_en all ones, so the PC loads the target.
     - mc_start, load_use and halt_req are ignored this cycle.
  2. mc_start with MC_LAT>1:
     - stage_en[0..2]=0, stage_flush[3]=1 (bubble into EX/MEM), stage_en[4]=1.
     - Load mc counter with MC_LAT-2 and go to MC_WAIT.
     - load_use and halt_req are ignored.
     - With MC_LAT=1, mc_start is treated as absent.
  3. load_use:
     - stage_en[0]=stage_en[1]=0, stage_flush[2]=1 (bubble into ID/EX), stage_en[3..4]=1.
     - State stays RUN; halt_req is ignored.
  4. halt_req:
     - stage_en[0]=stage_en[1]=0, stage_flush[2]=1.
     - Load drain counter with 2 and go to DRAIN.
- MC_WAIT:
  - If counter>0: same outputs as the mc_start cycle; counter decrements.
  - If counter==0: RUN default outputs (EX/MEM captures the result), go to RUN.
  - Total freeze is MC_LAT-1 cycles, counting the mc_start cycle.
  - All hazard inputs are ignored in this state.
- DRAIN:
  - stage_en[0]=stage_en[1]=0, stage_flush[1]=1, stage_en[2..4]=1, with stage_flush[2]=1 so no new work enters EX.
  - Counter decrements each cycle.
  - When counter==0: set halted=1 and go to IDLE next edge.
  - DRAIN lasts 3 cycles, so EX, MEM and WB retire.
- stall_count:
  - Increments on each clk edge where state≠IDLE and stage_en[0]==0.
  - Saturates at 2^CNT_W-1.
- branch_taken and mc_start asserted together is illegal; the bench asserts against it. The RTL resolves it as branch wins.

Decomposition:
- Package `pipeline_control_pkg` holds:
  - the state enum (IDLE, RUN, MC_WAIT, DRAIN);
  - stage index constants STG_PC=0, STG_IFID=1, STG_IDEX=2, STG_EXMEM=3, STG_MEMWB=4;
  - DRAIN_CYCLES=3.
- One sub-module, `sat_counter` (parameter WIDTH; inputs clr and inc), implements stall_count.

Test Plan:
- Reset then start pulse:
  - During reset: stage_en=5'b00000, stage_flush=5'b11111.
  - The cycle after start: running=1, stage_en=5'b11111, stage_flush=0.
- load_use held for 1 cycle in RUN:
  - stage_en=5'b11100, stage_flush=5'b00100 for exactly 1 cycle.
  - stall_count goes 0→1.
- mc_start in RUN with MC_LAT=4:
  - stage_en=5'b11000, stage_flush=5'b01000 for 3 consecutive cycles, then 5'b11111.
  - stall_count=3.
- branch_taken together with load_use:
  - stage_en=5'b11111, stage_flush=5'b00110; no stall occurs and stall_count is unchanged.
- halt_req in RUN:
  - 1 cycle of RUN halt outputs, then 3 DRAIN cycles with stage_en=5'b11100 and stage_flush=5'b00110.
  - Then IDLE with halted=1 and running=0.
  - A later start clears halted.
- Reset deasserted-then-asserted mid MC_WAIT (counter=1):
  - Outputs go to IDLE values immediately, without waiting for clk.
  - After release and start, the first cycle is the RUN default.
